// File: rtl/riscvboy_imem_loader.sv
// rtl/riscvboy_imem_loader.sv - boot loader: byte-stream frames into imem writes, holds core until loaded
// Optional checksum byte: define RISCVBOY_LOADER_CSUM_EN.
module riscvboy_imem_loader #(
   parameter int INSTR_WIDTH = 32,
   parameter int MEM_DEPTH   = 2048,
   parameter int ADDR_W      = 12
) (
   input  logic                   clk_sys,
   input  logic                   rst,
   input  logic                   i_rx_valid,
   input  logic [7:0]             i_rx_data,
   output logic                   o_rx_ready,
   input  logic                   i_skip,
   output logic                   o_instr_wena,
   output logic [ADDR_W-1:0]      o_instr_waddra,
   output logic [INSTR_WIDTH-1:0] o_instr_dina,
   output logic                   o_core_hold,
   output logic                   o_done,
   output logic                   o_err
);

   typedef enum logic [2:0] {
      ST_SYNC, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM, ST_DONE, ST_ERR
   } state_t;

   localparam logic [7:0]  LP_SYNC_BYTE = 8'hA5;
   localparam logic [16:0] LP_DEPTH     = 17'(MEM_DEPTH);

   state_t                  r_state;
   logic [15:0]             r_len;
   logic [1:0]              r_byte_idx;
   logic [ADDR_W-1:0]       r_addr;
   logic [INSTR_WIDTH-1:0]  r_word;
`ifdef RISCVBOY_LOADER_CSUM_EN
   logic [7:0]              r_sum;
`endif

   logic        w_fire;
   logic [15:0] w_n;
   logic        w_last;

   assign w_fire = i_rx_valid & o_rx_ready;
   assign w_n    = {i_rx_data, r_len[7:0]};
   // r_addr still points at the word being completed when byte 3 arrives
   assign w_last = ({{(16-ADDR_W){1'b0}}, r_addr} == (r_len - 16'd1));

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_state        <= ST_SYNC;
         r_len          <= '0;
         r_byte_idx     <= '0;
         r_addr         <= '0;
         r_word         <= '0;
`ifdef RISCVBOY_LOADER_CSUM_EN
         r_sum          <= '0;
`endif
         o_rx_ready     <= 1'b1;
         o_instr_wena   <= 1'b0;
         o_instr_waddra <= '0;
         o_instr_dina   <= '0;
         o_core_hold    <= 1'b1;
         o_done         <= 1'b0;
         o_err          <= 1'b0;
      end else begin
         o_instr_wena <= 1'b0;
         case (r_state)
            ST_SYNC, ST_ERR: begin
               if (i_skip) begin
                  r_state     <= ST_DONE;
                  o_done      <= 1'b1;
                  o_core_hold <= 1'b0;
                  o_rx_ready  <= 1'b0;
                  o_err       <= 1'b0;
               end else if (w_fire && i_rx_data == LP_SYNC_BYTE) begin
                  r_state <= ST_LEN0;
                  o_err   <= 1'b0;
               end
            end
            ST_LEN0: begin
               if (w_fire) begin
                  r_len   <= {8'h00, i_rx_data};
                  r_state <= ST_LEN1;
               end
            end
            ST_LEN1: begin
               if (w_fire) begin
                  r_len      <= w_n;
                  r_addr     <= '0;
                  r_byte_idx <= '0;
`ifdef RISCVBOY_LOADER_CSUM_EN
                  r_sum      <= '0;
`endif
                  if ({1'b0, w_n} > LP_DEPTH) begin
                     r_state <= ST_ERR;
                     o_err   <= 1'b1;
                  end else if (w_n == 16'd0) begin
`ifdef RISCVBOY_LOADER_CSUM_EN
                     r_state <= ST_CSUM;
`else
                     r_state     <= ST_DONE;
                     o_done      <= 1'b1;
                     o_core_hold <= 1'b0;
                     o_rx_ready  <= 1'b0;
`endif
                  end else begin
                     r_state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (w_fire) begin
                  r_word     <= {i_rx_data, r_word[INSTR_WIDTH-1:8]};
                  r_byte_idx <= r_byte_idx + 2'd1;
`ifdef RISCVBOY_LOADER_CSUM_EN
                  r_sum      <= r_sum + i_rx_data;
`endif
                  if (r_byte_idx == 2'd3) begin
                     o_instr_wena   <= 1'b1;
                     o_instr_waddra <= r_addr;
                     o_instr_dina   <= {i_rx_data, r_word[INSTR_WIDTH-1:8]};
                     r_addr         <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                     if (w_last) begin
`ifdef RISCVBOY_LOADER_CSUM_EN
                        r_state <= ST_CSUM;
`else
                        r_state     <= ST_DONE;
                        o_done      <= 1'b1;
                        o_core_hold <= 1'b0;
                        o_rx_ready  <= 1'b0;
`endif
                     end
                  end
               end
            end
            ST_CSUM: begin
`ifdef RISCVBOY_LOADER_CSUM_EN
               if (w_fire) begin
                  if (i_rx_data == r_sum) begin
                     r_state     <= ST_DONE;
                     o_done      <= 1'b1;
                     o_core_hold <= 1'b0;
                     o_rx_ready  <= 1'b0;
                  end else begin
                     r_state <= ST_ERR;
                     o_err   <= 1'b1;
                  end
               end
`else
               r_state <= ST_SYNC;
`endif
            end
            ST_DONE: r_state <= ST_DONE;
            default: r_state <= ST_SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_riscvboy_imem_loader.sv
// tb/tb_riscvboy_imem_loader.sv - directed self-checking bench for riscvboy_imem_loader
// Works with or without RISCVBOY_LOADER_CSUM_EN defined.
module tb_riscvboy_imem_loader;

   logic        clk_sys = 1'b0;
   logic        rst = 1'b1;
   logic        i_rx_valid = 1'b0;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_skip = 1'b0;
   logic        o_rx_ready;
   logic        o_instr_wena;
   logic [11:0] o_instr_waddra;
   logic [31:0] o_instr_dina;
   logic        o_core_hold;
   logic        o_done;
   logic        o_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [11:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   riscvboy_imem_loader #(.INSTR_WIDTH(32), .MEM_DEPTH(2048), .ADDR_W(12)) dut (
      .clk_sys        (clk_sys),
      .rst            (rst),
      .i_rx_valid     (i_rx_valid),
      .i_rx_data      (i_rx_data),
      .o_rx_ready     (o_rx_ready),
      .i_skip         (i_skip),
      .o_instr_wena   (o_instr_wena),
      .o_instr_waddra (o_instr_waddra),
      .o_instr_dina   (o_instr_dina),
      .o_core_hold    (o_core_hold),
      .o_done         (o_done),
      .o_err          (o_err)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (o_instr_wena) begin
         wr_addr_q.push_back(o_instr_waddra);
         wr_data_q.push_back(o_instr_dina);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      @(posedge clk_sys);
      #1;
      i_rx_valid = 1'b0;
      i_rx_data  = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk_sys);
      #1;
      rst = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic check_released(input string name);
      n_checks++;
      if (o_done !== 1'b1 || o_core_hold !== 1'b0 || o_rx_ready !== 1'b0 || o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s release: done=%b hold=%b ready=%b err=%b required 1 0 0 0",
                  name, o_done, o_core_hold, o_rx_ready, o_err);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (o_core_hold !== 1'b1 || o_rx_ready !== 1'b1 || o_instr_wena !== 1'b0 ||
          o_instr_waddra !== 12'h000 || o_instr_dina !== 32'h0 || o_done !== 1'b0 || o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: hold=%b ready=%b wena=%b addr=%h dina=%h done=%b err=%b required 1 1 0 000 00000000 0 0",
                  name, o_core_hold, o_rx_ready, o_instr_wena, o_instr_waddra, o_instr_dina, o_done, o_err);
      end
   endtask

   task automatic send_basic_frame();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      n_checks++;
      if (o_instr_wena !== 1'b1 || o_instr_waddra !== 12'h000 || o_instr_dina !== 32'h00000013) begin
         n_fail++;
         $display("FAIL word0_write: wena=%b addr=%h data=%h required 1 000 00000013",
                  o_instr_wena, o_instr_waddra, o_instr_dina);
      end
      send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      n_checks++;
      if (o_instr_wena !== 1'b1 || o_instr_waddra !== 12'h001 || o_instr_dina !== 32'h0000006F) begin
         n_fail++;
         $display("FAIL word1_write: wena=%b addr=%h data=%h required 1 001 0000006F",
                  o_instr_wena, o_instr_waddra, o_instr_dina);
      end
   endtask

   task automatic check_basic_writes(input string name);
      n_checks++;
      if (wr_addr_q.size() != 2) begin
         n_fail++;
         $display("FAIL %s write_count: got %0d required 2", name, wr_addr_q.size());
      end else if (wr_addr_q[0] !== 12'h000 || wr_data_q[0] !== 32'h00000013 ||
                   wr_addr_q[1] !== 12'h001 || wr_data_q[1] !== 32'h0000006F) begin
         n_fail++;
         $display("FAIL %s writes: got %h=%h %h=%h required 000=00000013 001=0000006F",
                  name, wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
      end
   endtask

   task automatic test_reset();
      check_reset_outputs("reset_state");
   endtask

   task automatic test_basic();
      do_reset();
      send_basic_frame();
`ifdef RISCVBOY_LOADER_CSUM_EN
      n_checks++;
      if (o_done !== 1'b0 || o_core_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_wait_csum: done=%b hold=%b required 0 1", o_done, o_core_hold);
      end
      send_byte(8'h82);
`endif
      check_released("basic");
      repeat (2) @(posedge clk_sys);
      #1;
      check_basic_writes("basic");
   endtask

`ifdef RISCVBOY_LOADER_CSUM_EN
   task automatic test_csum_err();
      do_reset();
      send_basic_frame();
      send_byte(8'h83);
      n_checks++;
      if (o_err !== 1'b1 || o_core_hold !== 1'b1 || o_done !== 1'b0 || o_rx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL csum_err: err=%b hold=%b done=%b ready=%b required 1 1 0 1",
                  o_err, o_core_hold, o_done, o_rx_ready);
      end
      @(posedge clk_sys);
      #1;
      check_basic_writes("csum_err");
      send_byte(8'hA5);
      n_checks++;
      if (o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL csum_err_clear: err=%b required 0", o_err);
      end
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check_released("csum_err_recover");
   endtask
`endif

   task automatic test_oversize();
      do_reset();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h08);
      n_checks++;
      if (o_err !== 1'b1 || o_core_hold !== 1'b1 || o_rx_ready !== 1'b1 || o_done !== 1'b0) begin
         n_fail++;
         $display("FAIL oversize_err: err=%b hold=%b ready=%b done=%b required 1 1 1 0",
                  o_err, o_core_hold, o_rx_ready, o_done);
      end
      send_byte(8'h11); send_byte(8'h22);
      n_checks++;
      if (wr_addr_q.size() != 0 || o_err !== 1'b1) begin
         n_fail++;
         $display("FAIL oversize_no_write: writes=%0d err=%b required 0 1", wr_addr_q.size(), o_err);
      end
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
`ifdef RISCVBOY_LOADER_CSUM_EN
      send_byte(8'h00);
`endif
      check_released("oversize_recover");
   endtask

   task automatic test_max_len();
      logic [7:0] sum;
      int         bad;
      logic [15:0] iw;
      do_reset();
      sum = 8'h00;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h08);
      for (int i = 0; i < 2048; i++) begin
         iw = 16'(i);
         send_byte(iw[7:0]); send_byte(iw[15:8]); send_byte(8'h00); send_byte(8'h00);
         sum = sum + iw[7:0] + iw[15:8];
      end
`ifdef RISCVBOY_LOADER_CSUM_EN
      send_byte(sum);
`endif
      check_released("max_len");
      @(posedge clk_sys);
      #1;
      n_checks++;
      if (wr_addr_q.size() != 2048) begin
         n_fail++;
         $display("FAIL max_len_count: got %0d required 2048", wr_addr_q.size());
      end else begin
         bad = 0;
         for (int i = 0; i < 2048; i++)
            if (wr_addr_q[i] !== 12'(i) || wr_data_q[i] !== 32'(i)) bad++;
         if (bad != 0 || wr_addr_q[2047] !== 12'h7FF) begin
            n_fail++;
            $display("FAIL max_len_data: %0d bad words, last addr=%h required 0 bad, 7FF",
                     bad, wr_addr_q[2047]);
         end
      end
   endtask

   task automatic test_skip();
      do_reset();
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      n_checks++;
      if (o_done !== 1'b0 || o_core_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL skip_junk: done=%b hold=%b required 0 1", o_done, o_core_hold);
      end
      i_skip = 1'b1;
      @(posedge clk_sys);
      #1;
      i_skip = 1'b0;
      check_released("skip");
      n_checks++;
      if (wr_addr_q.size() != 0) begin
         n_fail++;
         $display("FAIL skip_no_write: writes=%0d required 0", wr_addr_q.size());
      end
   endtask

   task automatic test_skip_vs_sync();
      do_reset();
      i_skip = 1'b1;
      send_byte(8'hA5);
      i_skip = 1'b0;
      check_released("skip_vs_sync");
   endtask

   task automatic test_skip_in_data();
      do_reset();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h78);
      i_skip = 1'b1;
      send_byte(8'h56);
      i_skip = 1'b0;
      n_checks++;
      if (o_done !== 1'b0 || o_core_hold !== 1'b1 || o_rx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL skip_in_data_ignored: done=%b hold=%b ready=%b required 0 1 1",
                  o_done, o_core_hold, o_rx_ready);
      end
      send_byte(8'h34); send_byte(8'h12);
      n_checks++;
      if (o_instr_wena !== 1'b1 || o_instr_waddra !== 12'h000 || o_instr_dina !== 32'h12345678) begin
         n_fail++;
         $display("FAIL skip_in_data_write: wena=%b addr=%h data=%h required 1 000 12345678",
                  o_instr_wena, o_instr_waddra, o_instr_dina);
      end
`ifdef RISCVBOY_LOADER_CSUM_EN
      send_byte(8'h14);
`endif
      check_released("skip_in_data");
   endtask

   task automatic test_rst_mid();
      do_reset();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66);
      rst = 1'b1;
      #2;
      check_reset_outputs("rst_mid_async");
      @(posedge clk_sys);
      #1;
      rst = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
      send_basic_frame();
`ifdef RISCVBOY_LOADER_CSUM_EN
      send_byte(8'h82);
`endif
      check_released("rst_mid_reload");
      @(posedge clk_sys);
      #1;
      check_basic_writes("rst_mid_reload");
   endtask

   initial begin
      @(posedge clk_sys);
      @(posedge clk_sys);
      #1;
      rst = 1'b0;
      test_reset();
      test_basic();
`ifdef RISCVBOY_LOADER_CSUM_EN
      test_csum_err();
`endif
      test_oversize();
      test_max_len();
      test_skip();
      test_skip_vs_sync();
      test_skip_in_data();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
